// File: rtl/sio_pkg.sv
// sio_pkg: shared state encoding and constants for the simple I/O stimulus checker.
// Contents: state_t (IDLE/RUN/DONE), SIO_WIDTH default pin width, SIO_MIN/SIO_MAX pin range.
package sio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SIO_WIDTH = 11;
    localparam int SIO_MIN   = 0;
    localparam int SIO_MAX   = 100;

endpackage

// File: rtl/sio_seq_mem.sv
// sio_seq_mem: paired stimulus/expected sequence arrays, one write port, one combinational read port.
// Ports: clk; we/waddr/wstim/wexp write one entry (waddr >= DEPTH ignored);
//        raddr selects the entry shown on rstim/rexp.
// Build option: SIO_CLAMP_EN clamps wstim (as signed) to SIO_MIN..SIO_MAX on write.
module sio_seq_mem
    import sio_pkg::*;
#(
    parameter int WIDTH  = SIO_WIDTH,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wstim,
    input  logic [WIDTH-1:0]  wexp,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rstim,
    output logic [WIDTH-1:0]  rexp
);

    logic [WIDTH-1:0] stim_mem [DEPTH];
    logic [WIDTH-1:0] exp_mem  [DEPTH];
    logic [WIDTH-1:0] stim_w;

`ifdef SIO_CLAMP_EN
    logic signed [WIDTH-1:0] s;
    assign s      = $signed(wstim);
    // Sign bit first so negative inputs never reach the signed upper-bound compare.
    assign stim_w = s[WIDTH-1] ? WIDTH'(SIO_MIN)
                  : (s > $signed(WIDTH'(SIO_MAX)) ? WIDTH'(SIO_MAX) : wstim);
`else
    assign stim_w = wstim;
`endif

    always_ff @(posedge clk) begin
        if (we && int'(waddr) < DEPTH) begin
            stim_mem[waddr] <= stim_w;
            exp_mem[waddr]  <= wexp;
        end
    end

    assign rstim = stim_mem[raddr];
    assign rexp  = exp_mem[raddr];

endmodule

// File: rtl/sio_stimulus_checker.sv
// sio_stimulus_checker: far-end model of one simple I/O pin; drives stimulus, checks chip output.
// Ports: clk, rst (async, active-high); load_en/load_addr/load_stim/load_expect fill the sequence;
//        seq_len/start begin a run; step ends each time unit; chip_out is checked;
//        chip_in, busy, done, pass, mismatch_cnt, fail_idx report the run.
// Build option: SIO_CLAMP_EN clamps loaded stimulus to 0..100 (see sio_seq_mem).
module sio_stimulus_checker
    import sio_pkg::*;
#(
    parameter int WIDTH  = SIO_WIDTH,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WIDTH-1:0]  load_stim,
    input  logic [WIDTH-1:0]  load_expect,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              start,
    input  logic              step,
    input  logic [WIDTH-1:0]  chip_out,
    output logic [WIDTH-1:0]  chip_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   mismatch_cnt,
    output logic [ADDR_W-1:0] fail_idx
);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   len_new;
    logic [WIDTH-1:0]  rstim;
    logic [WIDTH-1:0]  rexp;
    logic [WIDTH-1:0]  exp_q;
    logic              miss;
    logic              last;

    // The read port looks one entry ahead so the next stimulus/expected pair is ready
    // on the step edge; exp_q holds the expected value for the step in progress.
    assign raddr   = state == RUN ? idx + 1'b1 : '0;
    assign len_new = seq_len > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : seq_len;
    assign miss    = chip_out != exp_q;
    assign last    = {1'b0, idx} == len - 1'b1;
    assign busy    = state == RUN;
    assign done    = state == DONE;

    sio_seq_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (load_en && state != RUN),
        .waddr (load_addr),
        .wstim (load_stim),
        .wexp  (load_expect),
        .raddr (raddr),
        .rstim (rstim),
        .rexp  (rexp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            len          <= '0;
            chip_in      <= '0;
            exp_q        <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            fail_idx     <= '0;
        end else if (state != RUN) begin
            if (start) begin
                len          <= len_new;
                idx          <= '0;
                mismatch_cnt <= '0;
                fail_idx     <= '0;
                pass         <= len_new == '0;
                state        <= len_new == '0 ? DONE : RUN;
                chip_in      <= len_new == '0 ? '0 : rstim;
                exp_q        <= rexp;
            end
        end else if (step) begin
            if (miss) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
                if (mismatch_cnt == '0)
                    fail_idx <= idx;
            end
            if (last) begin
                state <= DONE;
                pass  <= mismatch_cnt == '0 && !miss;
            end else begin
                idx     <= idx + 1'b1;
                chip_in <= rstim;
                exp_q   <= rexp;
            end
        end
    end

endmodule

// File: tb/tb_sio_stimulus_checker.sv
// tb_sio_stimulus_checker: table-driven directed bench for sio_stimulus_checker plus a reset-abort sequence.
module tb_sio_stimulus_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [10:0] load_stim = '0;
    logic [10:0] load_expect = '0;
    logic [4:0]  seq_len = '0;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic [10:0] chip_out = '0;
    logic [10:0] chip_in;
    logic        busy, done, pass;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  fail_idx;

    int checks = 0;
    int failures = 0;

`ifdef SIO_CLAMP_EN
    localparam logic [10:0] C_NEG = 11'd0;
    localparam logic [10:0] C_BIG = 11'd100;
`else
    localparam logic [10:0] C_NEG = 11'h7FB;
    localparam logic [10:0] C_BIG = 11'd500;
`endif

    always #5 clk = ~clk;

    sio_stimulus_checker dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_stim    (load_stim),
        .load_expect  (load_expect),
        .seq_len      (seq_len),
        .start        (start),
        .step         (step),
        .chip_out     (chip_out),
        .chip_in      (chip_in),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .mismatch_cnt (mismatch_cnt),
        .fail_idx     (fail_idx)
    );

    typedef struct {
        logic        ld;
        logic [3:0]  addr;
        logic [10:0] stim;
        logic [10:0] expv;
        logic [4:0]  slen;
        logic        st;
        logic        sp;
        logic [10:0] cout;
        logic [10:0] cin;
        logic        busy;
        logic        done;
        logic        pass;
        logic [4:0]  cnt;
        logic [3:0]  fidx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ld, logic [3:0] addr, logic [10:0] stim, logic [10:0] expv,
                                logic [4:0] slen, logic st, logic sp, logic [10:0] cout,
                                logic [10:0] cin, logic b, logic d, logic p,
                                logic [4:0] cnt, logic [3:0] fidx);
        vec_t v;
        v.ld = ld; v.addr = addr; v.stim = stim; v.expv = expv; v.slen = slen;
        v.st = st; v.sp = sp; v.cout = cout; v.cin = cin; v.busy = b; v.done = d;
        v.pass = p; v.cnt = cnt; v.fidx = fidx;
        return v;
    endfunction

    task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, n, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input int n, input logic [10:0] cin, input logic b,
                           input logic d, input logic p, input logic [4:0] cnt, input logic [3:0] fidx);
        chk({tag, ".chip_in"}, n, 32'(chip_in), 32'(cin));
        chk({tag, ".busy"}, n, 32'(busy), 32'(b));
        chk({tag, ".done"}, n, 32'(done), 32'(d));
        chk({tag, ".pass"}, n, 32'(pass), 32'(p));
        chk({tag, ".cnt"}, n, 32'(mismatch_cnt), 32'(cnt));
        chk({tag, ".fidx"}, n, 32'(fail_idx), 32'(fidx));
    endtask

    task automatic drive(input logic ld, input logic [3:0] addr, input logic [10:0] stim,
                         input logic [10:0] expv, input logic [4:0] slen, input logic st,
                         input logic sp, input logic [10:0] cout);
        load_en = ld; load_addr = addr; load_stim = stim; load_expect = expv;
        seq_len = slen; start = st; step = sp; chip_out = cout;
        @(posedge clk);
        #1;
        load_en = 1'b0; start = 1'b0; step = 1'b0;
    endtask

    initial begin
        // ld addr stim expv slen st sp cout | cin busy done pass cnt fidx
        vecs.push_back(mk(1, 0, 5,   0,  0, 0, 0, 0,   0,   0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 50,  10, 0, 0, 0, 0,   0,   0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 100, 20, 0, 0, 0, 0,   0,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  3, 1, 0, 0,   5,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 1, 0,   50,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 1, 10,  100, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 1, 20,  100, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 1, 99,  100, 0, 1, 1, 0, 0));
        // mismatching run
        vecs.push_back(mk(0, 0, 0,   0,  3, 1, 0, 0,   5,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 1, 0,   50,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 1, 11,  100, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 1, 21,  100, 0, 1, 0, 2, 1));
        // zero-length run
        vecs.push_back(mk(0, 0, 0,   0,  0, 1, 0, 0,   0,   0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 0, 0,   0,   0, 1, 1, 0, 0));
        // load during RUN ignored
        vecs.push_back(mk(0, 0, 0,   0,  3, 1, 0, 0,   5,   1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 99,  99, 0, 0, 1, 0,   50,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 1, 10,  100, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 1, 20,  100, 0, 1, 1, 0, 0));
        // start and step together: start only, stim[0] still 5
        vecs.push_back(mk(0, 0, 0,   0,  3, 1, 1, 7,   5,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 1, 0,   50,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 1, 10,  100, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,  0, 0, 1, 20,  100, 0, 1, 1, 0, 0));
        // seq_len above DEPTH clamps to 16 entries: run starts normally
        vecs.push_back(mk(0, 0, 0,   0,  31, 1, 0, 0,  5,   1, 0, 0, 0, 0));
    end

    initial begin
        #2;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ld, vecs[i].addr, vecs[i].stim, vecs[i].expv, vecs[i].slen,
                  vecs[i].st, vecs[i].sp, vecs[i].cout);
            chk_all("vec", i, vecs[i].cin, vecs[i].busy, vecs[i].done, vecs[i].pass,
                    vecs[i].cnt, vecs[i].fidx);
        end

        // abort the 16-step run above after one step with an asynchronous reset
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk_all("abort_pre", 0, 50, 1, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk_all("abort", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 0, 0, 3, 1, 0, 0);
        chk_all("rerun", 0, 5, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        chk_all("rerun", 1, 50, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 10);
        drive(0, 0, 0, 0, 0, 0, 1, 20);
        chk_all("rerun", 2, 100, 0, 1, 0, 1, 0);

        // stimulus clamp behaviour on write
        drive(1, 0, 11'h7FB, 0, 0, 0, 0, 0);
        drive(1, 1, 11'd500, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 2, 1, 0, 0);
        chk_all("clamp", 0, C_NEG, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk_all("clamp", 1, C_BIG, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk_all("clamp", 2, C_BIG, 0, 1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sio_stimulus_checker.md
Name: sio_stimulus_checker

Overview:
- Models the external device at the far end of one MC3999 simple I/O pin.
- Drives the chip's pin input (chip_in feeds p0_in/p1_in) from a loaded stimulus sequence, one value per time step.
- On each time step, samples the chip's pin output (chip_out from p0_out/p1_out) and compares it against an expected sequence.
- Reports pass/fail, the mismatch count and the first failing step; used as the bench-side peripheral in chip-level puzzle tests.

Parameters:
- WIDTH, 11, pin data width; matches the register-file data path.
- DEPTH, 16, maximum sequence length in time steps.
- ADDR_W, 4, index width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  write one sequence entry this cycle.
- load_addr  in  ADDR_W  entry index to write.
- load_stim  in  WIDTH  stimulus value for that step.
- load_expect  in  WIDTH  expected chip output for that step.
- seq_len  in  ADDR_W+1  number of steps, 0..DEPTH; latched on start.
- start  in  1  single-cycle pulse that begins a run.
- step  in  1  single-cycle pulse marking the end of one time unit.
- chip_out  in  WIDTH  chip pin output under test.
- chip_in  out  WIDTH  value driven onto the chip pin input.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE; held until the next start or rst.
- pass  out  1  valid only while done; 1 when mismatch_cnt == 0.
- mismatch_cnt  out  ADDR_W+1  number of mismatching steps.
- fail_idx  out  ADDR_W  index of the first mismatch; 0 if none.

Behaviour:
- Reset (asynchronous, active-high) returns every output to 0 and the state to IDLE.
- Stimulus and expected arrays are not reset.
- States are IDLE, RUN and DONE.
- Loading:
  - When load_en is high in IDLE or DONE, both arrays are written at load_addr on that edge.
  - load_en is ignored in RUN.
  - load_addr >= DEPTH is ignored.
- Start:
  - start in IDLE or DONE latches len = min(seq_len, DEPTH) and clears mismatch_cnt, fail_idx, done and pass.
  - If len == 0: go to DONE on the same edge with pass = 1 and chip_in = 0.
  - Otherwise: go to RUN with idx = 0 and chip_in = stim[0], visible the cycle after start.
  - start in RUN is ignored.
- Step in RUN:
  - On the edge where step is high, chip_out is compared with expect[idx]. The comparison is a full-width bit compare; chip_out is sampled in that same cycle.
  - On a mismatch, mismatch_cnt increments. If it was 0, fail_idx is set to idx.
  - If idx == len-1: go to DONE; chip_in holds its last value; done = 1; pass = (final count == 0).
  - Otherwise: idx increments and chip_in = stim[idx+1] on the next cycle. The stimulus for step k+1 therefore appears one cycle after step pulse k.
- step in IDLE or DONE is ignored.
- If start and step are high together in IDLE or DONE, start takes effect and step is ignored.
- mismatch_cnt cannot overflow, since its maximum value is DEPTH.
- rst during RUN aborts immediately: IDLE, chip_in = 0, counters cleared.
- chip_in stays registered. No combinational path from any input to any output.

Optional Feature:
- Macro: SIO_CLAMP_EN.
- Defined: load_stim is treated as signed and clamped to the simple I/O range 0..100 on write; negative values store 0 and values above 100 store 100. Expected values are not clamped.
- Not defined: load_stim is stored unmodified.

Decomposition:
- Shared package/include sio_pkg holds:
  - the state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - the WIDTH default;
  - the constants SIO_MIN = 0 and SIO_MAX = 100.
- One natural sub-module, sio_seq_mem: paired DEPTH x WIDTH stimulus/expected arrays with one write port and one combinational read port indexed by idx, including the clamp logic.

Test Plan:
- Load len 3, stim {5, 50, 100}, expect {0, 10, 20}; start; chip_out = {0, 10, 20} on successive steps -> chip_in walks 5→50→100; done = 1, pass = 1, mismatch_cnt = 0.
- Same load; chip_out = {0, 11, 21} -> mismatch_cnt = 2, fail_idx = 1, pass = 0.
- seq_len = 0 with start -> done = 1 and pass = 1 on the next cycle; busy never asserts.
- Assert rst after step 1 of a 3-step run -> chip_in = 0 and state IDLE immediately; a later start re-runs from idx 0 using the retained arrays.
- load_en during RUN writing addr 0 = 99 -> ignored; stim[0] is unchanged on rerun. Start and step in the same cycle -> start only.
- SIO_CLAMP_EN defined: load_stim = -5 and 500 -> chip_in shows 0 and 100. Not defined: the same loads show 11'h7FB and 500.
